// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and constants for the register file slice.
//   WORD_LN      data word width
//   REG_IDX_LN   architectural register index width
//   ROB_IDX_LN   default ROB tag width; tag 0 means "no pending producer"
//   reg_is_live  true for every register except the hardwired x0
package reg_file_pkg;

    localparam int WORD_LN    = 32;
    localparam int REG_IDX_LN = 5;
    localparam int ROB_IDX_LN = 4;

    typedef logic [WORD_LN-1:0]    word_t;
    typedef logic [REG_IDX_LN-1:0] reg_idx_t;

    localparam word_t    ZERO_WORD    = '0;
    localparam reg_idx_t ZERO_REG_IDX = '0;

    function automatic logic reg_is_live(input reg_idx_t r);
        return r != ZERO_REG_IDX;
    endfunction

endpackage

// File: rtl/reg_file_rename_table.sv
// reg_rename_table: per-register ROB tag array.
//   Records which ROB entry will produce each register's next value, clears a
//   tag when its own producer commits, and clears every tag on ROB rollback.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global ready; low holds the table
//   rob_rb_ena          rollback: every tag returns to 0
//   reg_wr_ena/rd/idx   commit port; clears tag[rd] when it still names idx
//   id_rn_ena/rd/idx    rename port; tag[rd] <= idx
//   id_rs1/id_rs2       read indices
//   tag_rs1/tag_rs2     current tags (x0 always reads 0)
module reg_rename_table
    import reg_file_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int ROB_BIT = ROB_IDX_LN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rob_rb_ena,
    input  logic               reg_wr_ena,
    input  reg_idx_t           reg_wr_rd,
    input  logic [ROB_BIT-1:0] reg_wr_idx,
    input  logic               id_rn_ena,
    input  reg_idx_t           id_rn_rd,
    input  logic [ROB_BIT-1:0] id_rn_idx,
    input  reg_idx_t           id_rs1,
    input  reg_idx_t           id_rs2,
    output logic [ROB_BIT-1:0] tag_rs1,
    output logic [ROB_BIT-1:0] tag_rs2
);

    logic [ROB_BIT-1:0] tag [REG_NUM];

    always_ff @(posedge clk) begin
        for (int i = 0; i < REG_NUM; i++) begin
            if (rst || rob_rb_ena) begin
                // Rollback wins over any same-cycle rename.
                tag[i] <= '0;
            end else if (rdy && i != 0) begin
                if (id_rn_ena && id_rn_rd == REG_IDX_LN'(i)) begin
                    // A younger rename overrides the commit-clear of the same rd.
                    tag[i] <= id_rn_idx;
                end else if (reg_wr_ena && reg_wr_rd == REG_IDX_LN'(i) &&
                             tag[i] == reg_wr_idx) begin
                    tag[i] <= '0;
                end
            end
        end
    end

    assign tag_rs1 = reg_is_live(id_rs1) ? tag[id_rs1] : '0;
    assign tag_rs2 = reg_is_live(id_rs2) ? tag[id_rs2] : '0;

endmodule

// File: rtl/reg_file.sv
// reg_file: architectural register file plus rename-tag table, fed by the ROB
// commit port and read by the decoder.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   rdy                             global ready; low holds all state
//   rob_rb_ena                      ROB rollback: clears tags, commit value still lands
//   reg_wr_ena/rd/val/idx           ROB commit write
//   id_rs1/id_rs2                   decoder source indices
//   id_val1/id_val2                 source values (meaningful when id_src* is 0)
//   id_src1/id_src2                 source tags; 0 = value ready
//   id_rn_ena/rd/idx                rename of rd to ROB entry idx
// Optional build macro REGFILE_DBG_EN adds dbg_reg_sel / dbg_reg_val (raw
// value read, no bypass) and prints "rd=val" on every accepted commit.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int ROB_BIT = ROB_IDX_LN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rob_rb_ena,
    input  logic               reg_wr_ena,
    input  reg_idx_t           reg_wr_rd,
    input  word_t              reg_wr_val,
    input  logic [ROB_BIT-1:0] reg_wr_idx,
    input  reg_idx_t           id_rs1,
    input  reg_idx_t           id_rs2,
    output word_t              id_val1,
    output word_t              id_val2,
    output logic [ROB_BIT-1:0] id_src1,
    output logic [ROB_BIT-1:0] id_src2,
    input  logic               id_rn_ena,
    input  reg_idx_t           id_rn_rd,
    input  logic [ROB_BIT-1:0] id_rn_idx
`ifdef REGFILE_DBG_EN
    ,
    input  reg_idx_t           dbg_reg_sel,
    output word_t              dbg_reg_val
`endif
);

    word_t              val [REG_NUM];
    logic [ROB_BIT-1:0] tag_rs1;
    logic [ROB_BIT-1:0] tag_rs2;
    logic               commit_live;

    // A commit lands when the ROB presents it and the file is not held;
    // rollback outranks hold, so a rollback-cycle commit also lands.
    assign commit_live = reg_wr_ena && reg_is_live(reg_wr_rd) && (rdy || rob_rb_ena);

    reg_rename_table #(
        .REG_NUM (REG_NUM),
        .ROB_BIT (ROB_BIT)
    ) u_rename (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .rob_rb_ena (rob_rb_ena),
        .reg_wr_ena (reg_wr_ena),
        .reg_wr_rd  (reg_wr_rd),
        .reg_wr_idx (reg_wr_idx),
        .id_rn_ena  (id_rn_ena),
        .id_rn_rd   (id_rn_rd),
        .id_rn_idx  (id_rn_idx),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .tag_rs1    (tag_rs1),
        .tag_rs2    (tag_rs2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val[i] <= ZERO_WORD;
            end
        end else if (commit_live) begin
            val[reg_wr_rd] <= reg_wr_val;
`ifdef REGFILE_DBG_EN
            $display("x%0d=%h", reg_wr_rd, reg_wr_val);
`endif
        end
    end

    // Bypass only when the committing entry is the producer the tag is
    // waiting for; otherwise the old mapping (value or tag) is returned.
    always_comb begin
        id_val1 = ZERO_WORD;
        id_src1 = '0;
        if (reg_is_live(id_rs1)) begin
            if (commit_live && reg_wr_rd == id_rs1 && tag_rs1 == reg_wr_idx) begin
                id_val1 = reg_wr_val;
            end else begin
                id_val1 = val[id_rs1];
                id_src1 = tag_rs1;
            end
        end
    end

    always_comb begin
        id_val2 = ZERO_WORD;
        id_src2 = '0;
        if (reg_is_live(id_rs2)) begin
            if (commit_live && reg_wr_rd == id_rs2 && tag_rs2 == reg_wr_idx) begin
                id_val2 = reg_wr_val;
            end else begin
                id_val2 = val[id_rs2];
                id_src2 = tag_rs2;
            end
        end
    end

`ifdef REGFILE_DBG_EN
    assign dbg_reg_val = reg_is_live(dbg_reg_sel) ? val[dbg_reg_sel] : ZERO_WORD;
`endif

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;
  import reg_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rob_rb_ena;
  logic        reg_wr_ena;
  logic [4:0]  reg_wr_rd;
  logic [31:0] reg_wr_val;
  logic [3:0]  reg_wr_idx;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [31:0] id_val1;
  logic [31:0] id_val2;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_rn_ena;
  logic [4:0]  id_rn_rd;
  logic [3:0]  id_rn_idx;
`ifdef REGFILE_DBG_EN
  logic [4:0]  dbg_reg_sel = 5'd0;
  logic [31:0] dbg_reg_val;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .rob_rb_ena (rob_rb_ena),
    .reg_wr_ena (reg_wr_ena),
    .reg_wr_rd  (reg_wr_rd),
    .reg_wr_val (reg_wr_val),
    .reg_wr_idx (reg_wr_idx),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_val1    (id_val1),
    .id_val2    (id_val2),
    .id_src1    (id_src1),
    .id_src2    (id_src2),
    .id_rn_ena  (id_rn_ena),
    .id_rn_rd   (id_rn_rd),
    .id_rn_idx  (id_rn_idx)
`ifdef REGFILE_DBG_EN
    ,
    .dbg_reg_sel (dbg_reg_sel),
    .dbg_reg_val (dbg_reg_val)
`endif
  );

  // Inputs change #1 after the rising edge; reads are checked #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; rob_rb_ena = 1'b0;
    reg_wr_ena = 1'b0; reg_wr_rd = 5'd0; reg_wr_val = 32'h0; reg_wr_idx = 4'd0;
    id_rn_ena = 1'b0; id_rn_rd = 5'd0; id_rn_idx = 4'd0;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] idx);
    reg_wr_ena = 1'b1; reg_wr_rd = rd; reg_wr_val = v; reg_wr_idx = idx;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] idx);
    id_rn_ena = 1'b1; id_rn_rd = rd; id_rn_idx = idx;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    commit(5'd5, 32'hDEAD, 4'd1);
    tick(); tick();
    idle(); id_rs1 = 5'd5; id_rs2 = 5'd31; #1;
    checks++; if (id_val1 !== 32'h0) begin failures++; $display("FAIL reset_val1 got=%h exp=%h", id_val1, 32'h0); end
    checks++; if (id_src1 !== 4'd0) begin failures++; $display("FAIL reset_src1 got=%0d exp=0", id_src1); end
    checks++; if (id_val2 !== 32'h0 || id_src2 !== 4'd0) begin failures++; $display("FAIL reset_rs2 got=%h/%0d exp=0/0", id_val2, id_src2); end
  endtask

  task automatic test_commit_clean();
    idle(); id_rs1 = 5'd5;
    commit(5'd5, 32'h1234, 4'd3); #1;
    // No tag held: tag 0 != idx 3, so no bypass this cycle.
    checks++; if (id_val1 !== 32'h0) begin failures++; $display("FAIL clean_nobypass got=%h exp=%h", id_val1, 32'h0); end
    tick(); idle(); #1;
    checks++; if (id_val1 !== 32'h1234 || id_src1 !== 4'd0) begin failures++; $display("FAIL clean_commit got=%h/%0d exp=1234/0", id_val1, id_src1); end
  endtask

  task automatic test_rename_commit();
    idle(); id_rs1 = 5'd7; id_rs2 = 5'd5;
    rename(5'd7, 4'd4); #1;
    checks++; if (id_src1 !== 4'd0) begin failures++; $display("FAIL rename_same_cycle got=%0d exp=0", id_src1); end
    tick(); idle(); #1;
    checks++; if (id_src1 !== 4'd4) begin failures++; $display("FAIL rename_tag got=%0d exp=4", id_src1); end
    checks++; if (id_val2 !== 32'h1234 || id_src2 !== 4'd0) begin failures++; $display("FAIL dual_read got=%h/%0d exp=1234/0", id_val2, id_src2); end
    commit(5'd7, 32'hAA, 4'd4); #1;
    checks++; if (id_val1 !== 32'hAA || id_src1 !== 4'd0) begin failures++; $display("FAIL bypass got=%h/%0d exp=aa/0", id_val1, id_src1); end
    tick(); idle(); #1;
    checks++; if (id_val1 !== 32'hAA || id_src1 !== 4'd0) begin failures++; $display("FAIL commit_clear got=%h/%0d exp=aa/0", id_val1, id_src1); end
  endtask

  task automatic test_younger_rename();
    idle(); id_rs1 = 5'd7;
    rename(5'd7, 4'd5); tick(); idle();
    commit(5'd7, 32'hBB, 4'd4); #1;
    checks++; if (id_val1 !== 32'hAA || id_src1 !== 4'd5) begin failures++; $display("FAIL stale_commit_read got=%h/%0d exp=aa/5", id_val1, id_src1); end
    tick(); idle(); #1;
    checks++; if (id_val1 !== 32'hBB || id_src1 !== 4'd5) begin failures++; $display("FAIL stale_commit_keep got=%h/%0d exp=bb/5", id_val1, id_src1); end
    commit(5'd7, 32'hCC, 4'd5); rename(5'd7, 4'd6); #1;
    checks++; if (id_val1 !== 32'hCC || id_src1 !== 4'd0) begin failures++; $display("FAIL bypass_with_rename got=%h/%0d exp=cc/0", id_val1, id_src1); end
    tick(); idle(); #1;
    checks++; if (id_val1 !== 32'hCC || id_src1 !== 4'd6) begin failures++; $display("FAIL rename_beats_clear got=%h/%0d exp=cc/6", id_val1, id_src1); end
  endtask

  task automatic test_x0();
    idle(); id_rs1 = 5'd0; id_rs2 = 5'd0;
    commit(5'd0, 32'hFFFF, 4'd0); rename(5'd0, 4'd3); #1;
    checks++; if (id_val1 !== 32'h0 || id_src1 !== 4'd0) begin failures++; $display("FAIL x0_same_cycle got=%h/%0d exp=0/0", id_val1, id_src1); end
    tick(); idle(); #1;
    checks++; if (id_val2 !== 32'h0 || id_src2 !== 4'd0) begin failures++; $display("FAIL x0_after got=%h/%0d exp=0/0", id_val2, id_src2); end
  endtask

  task automatic test_rollback();
    idle();
    rename(5'd1, 4'd1); tick();
    rename(5'd2, 4'd2); tick();
    rename(5'd3, 4'd3); tick(); idle();
    id_rs1 = 5'd3; id_rs2 = 5'd2; #1;
    checks++; if (id_src1 !== 4'd3 || id_src2 !== 4'd2) begin failures++; $display("FAIL pre_rollback got=%0d/%0d exp=3/2", id_src1, id_src2); end
    rob_rb_ena = 1'b1; commit(5'd2, 32'h55, 4'd2); rename(5'd4, 4'd7);
    tick(); idle(); #1;
    checks++; if (id_src1 !== 4'd0) begin failures++; $display("FAIL rollback_x3 got=%0d exp=0", id_src1); end
    checks++; if (id_val2 !== 32'h55 || id_src2 !== 4'd0) begin failures++; $display("FAIL rollback_x2 got=%h/%0d exp=55/0", id_val2, id_src2); end
    id_rs1 = 5'd1; id_rs2 = 5'd4; #1;
    checks++; if (id_src1 !== 4'd0) begin failures++; $display("FAIL rollback_x1 got=%0d exp=0", id_src1); end
    checks++; if (id_src2 !== 4'd0) begin failures++; $display("FAIL rollback_rename_dropped got=%0d exp=0", id_src2); end
    id_rs1 = 5'd7; #1;
    checks++; if (id_val1 !== 32'hCC || id_src1 !== 4'd0) begin failures++; $display("FAIL rollback_x7 got=%h/%0d exp=cc/0", id_val1, id_src1); end
  endtask

  task automatic test_hold();
    idle(); id_rs1 = 5'd9; id_rs2 = 5'd10;
    rdy = 1'b0; commit(5'd9, 32'h9, 4'd1); rename(5'd10, 4'd2);
    tick(); tick(); #1;
    checks++; if (id_val1 !== 32'h0 || id_src1 !== 4'd0) begin failures++; $display("FAIL hold_commit got=%h/%0d exp=0/0", id_val1, id_src1); end
    checks++; if (id_src2 !== 4'd0) begin failures++; $display("FAIL hold_rename got=%0d exp=0", id_src2); end
    idle(); tick(); #1;
    checks++; if (id_val1 !== 32'h0 || id_src2 !== 4'd0) begin failures++; $display("FAIL hold_not_replayed got=%h/%0d exp=0/0", id_val1, id_src2); end
    // A tag held through rdy low is not cleared and the read is not bypassed.
    rename(5'd9, 4'd1); tick(); idle();
    rdy = 1'b0; commit(5'd9, 32'h9, 4'd1); #1;
    checks++; if (id_val1 !== 32'h0 || id_src1 !== 4'd1) begin failures++; $display("FAIL hold_no_bypass got=%h/%0d exp=0/1", id_val1, id_src1); end
    tick(); #1;
    checks++; if (id_src1 !== 4'd1) begin failures++; $display("FAIL hold_keep_tag got=%0d exp=1", id_src1); end
    rdy = 1'b1; rename(5'd10, 4'd2);
    tick(); idle(); #1;
    checks++; if (id_val1 !== 32'h9 || id_src1 !== 4'd0) begin failures++; $display("FAIL resume_commit got=%h/%0d exp=9/0", id_val1, id_src1); end
    checks++; if (id_src2 !== 4'd2) begin failures++; $display("FAIL resume_rename got=%0d exp=2", id_src2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] v;
    idle();
    for (int i = 0; i < 4; i++) begin
      v = $urandom_range(32'h7FFF_FFFF, 1);
      exp_q.push_back(v);
      commit(5'(11 + i), v, 4'(i + 1));
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      id_rs1 = 5'(11 + i); #1;
      v = exp_q.pop_front();
      checks++; if (id_val1 !== v || id_src1 !== 4'd0) begin failures++; $display("FAIL b2b_x%0d got=%h/%0d exp=%h/0", 11 + i, id_val1, id_src1, v); end
    end
  endtask

  task automatic test_reset_clears();
    idle(); rename(5'd12, 4'd3); tick();
    idle(); rst = 1'b1; tick(); idle();
    id_rs1 = 5'd9; id_rs2 = 5'd12; #1;
    checks++; if (id_val1 !== 32'h0 || id_val2 !== 32'h0 || id_src2 !== 4'd0) begin failures++; $display("FAIL reset_clears got=%h/%h/%0d exp=0/0/0", id_val1, id_val2, id_src2); end
  endtask

  initial begin
    idle(); rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0;
    test_reset();
    test_commit_clean();
    test_rename_commit();
    test_younger_rename();
    test_x0();
    test_rollback();
    test_hold();
    test_back_to_back();
    test_reset_clears();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
